// File: rtl/iso_hold_pkg.sv
// Shared types and constants for the isolation/hold controller.
// The ISO_HOLD_PARITY_EN macro (used by iso_hold_ctrl/iso_hold_chan) adds held-data parity checking.
package iso_hold_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_ISO     = 2'd2,
    ST_RELEASE = 2'd3
  } iso_state_e;

  // Raw clamp_mode encodings as they appear on the port
  localparam logic [1:0] MODE_HOLD     = 2'b00;
  localparam logic [1:0] MODE_ZERO     = 2'b01;
  localparam logic [1:0] MODE_ONE      = 2'b10;
  localparam logic [1:0] MODE_HOLD_ALT = 2'b11;

  typedef enum logic [1:0] {
    CLAMP_HOLD     = MODE_HOLD,
    CLAMP_ZERO     = MODE_ZERO,
    CLAMP_ONE      = MODE_ONE,
    CLAMP_HOLD_ALT = MODE_HOLD_ALT
  } clamp_mode_e;

  // Release down-counter width; covers release delays up to 255 cycles
  localparam int CNT_W = 8;

  // Collapse the spare encoding onto hold-last so the channel mux only sees three behaviours
  function automatic clamp_mode_e decode_mode(input logic [1:0] code);
    clamp_mode_e m;
    case (code)
      MODE_ZERO: m = CLAMP_ZERO;
      MODE_ONE:  m = CLAMP_ONE;
      default:   m = CLAMP_HOLD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/iso_hold_chan.sv
// One isolation channel: hold register plus output clamp mux.
// With ISO_HOLD_PARITY_EN defined, an even-parity bit is stored alongside the hold value
// and a mismatch is flagged whenever the channel is actively isolated.
module iso_hold_chan
  import iso_hold_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic             iso_en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
`ifdef ISO_HOLD_PARITY_EN
  ,output logic            par_bad
`endif
);

  logic [WIDTH-1:0] hold_q;
  clamp_mode_e      mode_dec;

  // Snapshot the channel input on the edge that leaves CAPTURE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (capture) begin
      hold_q <= data_in;
    end
  end

  // Pass through unless isolated; when isolated pick held value or a constant clamp
  always_comb begin
    data_out = data_in;
    mode_dec = decode_mode(mode);
    if (iso_en) begin
      case (mode_dec)
        CLAMP_ZERO: data_out = '0;
        CLAMP_ONE:  data_out = '1;
        default:    data_out = hold_q;
      endcase
    end
  end

`ifdef ISO_HOLD_PARITY_EN
  logic par_q;

  // Store even parity of the captured word for later integrity checks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (capture) begin
      par_q <= ^data_in;
    end
  end

  assign par_bad = iso_en && ((^hold_q) != par_q);
`endif

endmodule

// File: rtl/iso_hold_ctrl.sv
// Power-domain isolation controller: sequences RUN -> CAPTURE -> ISO -> RELEASE -> RUN,
// freezes channel mask and clamp mode at capture, and drives per-channel hold/clamp muxes.
// Optional feature macro: ISO_HOLD_PARITY_EN (sticky parity check of held data).
module iso_hold_ctrl
  import iso_hold_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NCH         = 4,
  parameter int RELEASE_DLY = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iso_req,
  output logic                 iso_ack,
  input  logic [NCH-1:0]       ch_mask,
  input  logic [1:0]           clamp_mode,
  input  logic [NCH*WIDTH-1:0] data_in,
  output logic [NCH*WIDTH-1:0] data_out,
  output logic [NCH-1:0]       iso_active,
  output logic                 parity_err
);

  iso_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic [NCH-1:0]   mask_q;
  logic [1:0]       mode_q;
  logic             capture;
  logic             iso_on;

  assign capture    = (state_q == ST_CAPTURE);
  assign iso_on     = (state_q == ST_ISO) || (state_q == ST_RELEASE);
  assign iso_active = iso_on ? mask_q : '0;
  assign iso_ack    = ack_q;

  // State, release counter and acknowledge registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state logic; a re-request during RELEASE wins over finishing the release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (iso_req) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_ISO;
      end
      ST_ISO: begin
        if (!iso_req) begin
          state_d = ST_RELEASE;
          cnt_d   = CNT_W'(RELEASE_DLY - 1);
        end
      end
      ST_RELEASE: begin
        if (iso_req) begin
          state_d = ST_ISO;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    ack_d = (state_d == ST_ISO) || (state_d == ST_RELEASE);
  end

  // Freeze mask and mode at capture so later input changes cannot disturb an isolation window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      mode_q <= MODE_HOLD;
    end else if (capture) begin
      mask_q <= ch_mask;
      mode_q <= clamp_mode;
    end
  end

`ifdef ISO_HOLD_PARITY_EN
  logic [NCH-1:0] par_bad;
  logic           perr_q;

  // Sticky parity error, cleared only when a fresh capture happens
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else if (capture) begin
      perr_q <= 1'b0;
    end else if (|par_bad) begin
      perr_q <= 1'b1;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  for (genvar n = 0; n < NCH; n++) begin : g_chan
    iso_hold_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .capture  (capture),
      .iso_en   (iso_on && mask_q[n]),
      .mode     (mode_q),
      .data_in  (data_in[n*WIDTH +: WIDTH]),
      .data_out (data_out[n*WIDTH +: WIDTH])
`ifdef ISO_HOLD_PARITY_EN
      ,.par_bad (par_bad[n])
`endif
    );
  end

endmodule

// File: tb/tb_iso_hold_ctrl.sv
// Directed bench for iso_hold_ctrl (WIDTH=8, NCH=4, RELEASE_DLY=3).
// Each step drives inputs on the falling edge, queues the expected outputs and checks them 1ns later.
module tb_iso_hold_ctrl;

  localparam int WIDTH       = 8;
  localparam int NCH         = 4;
  localparam int RELEASE_DLY = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 iso_req;
  logic                 iso_ack;
  logic [NCH-1:0]       ch_mask;
  logic [1:0]           clamp_mode;
  logic [NCH*WIDTH-1:0] data_in;
  logic [NCH*WIDTH-1:0] data_out;
  logic [NCH-1:0]       iso_active;
  logic                 parity_err;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        ack;
    logic [3:0]  act;
    logic        perr;
    bit          full;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt  = 0;
  int   fail_cnt = 0;

  logic [1:0]  mode_tab[3];
  logic [31:0] clamp_tab[3];

  always #5 clk = ~clk;

  iso_hold_ctrl #(
    .WIDTH       (WIDTH),
    .NCH         (NCH),
    .RELEASE_DLY (RELEASE_DLY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iso_req    (iso_req),
    .iso_ack    (iso_ack),
    .ch_mask    (ch_mask),
    .clamp_mode (clamp_mode),
    .data_in    (data_in),
    .data_out   (data_out),
    .iso_active (iso_active),
    .parity_err (parity_err)
  );

  task automatic applyStimulus(input string tag, input logic rst, input logic req,
                               input logic [3:0] mask, input logic [1:0] mode,
                               input logic [31:0] din, input logic [31:0] e_data,
                               input logic e_ack, input logic [3:0] e_act,
                               input logic e_perr, input bit full);
    exp_t e;
    rst_n      = rst;
    iso_req    = req;
    ch_mask    = mask;
    clamp_mode = mode;
    data_in    = din;
    e.tag  = tag;
    e.data = e_data;
    e.ack  = e_ack;
    e.act  = e_act;
    e.perr = e_perr;
    e.full = full;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      vec_cnt++;
      fail_cnt++;
      $display("[TB] FAIL scoreboard_empty: observed 0 entries, expected 1");
      return;
    end
    e = sb.pop_front();
    if (e.full) begin
      vec_cnt++;
      assert (data_out === e.data) else begin
        fail_cnt++;
        $error("[TB] FAIL %s data_out: observed %h expected %h", e.tag, data_out, e.data);
      end
      vec_cnt++;
      assert (iso_ack === e.ack) else begin
        fail_cnt++;
        $error("[TB] FAIL %s iso_ack: observed %b expected %b", e.tag, iso_ack, e.ack);
      end
      vec_cnt++;
      assert (iso_active === e.act) else begin
        fail_cnt++;
        $error("[TB] FAIL %s iso_active: observed %b expected %b", e.tag, iso_active, e.act);
      end
    end
    vec_cnt++;
    assert (parity_err === e.perr) else begin
      fail_cnt++;
      $error("[TB] FAIL %s parity_err: observed %b expected %b", e.tag, parity_err, e.perr);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic req,
                      input logic [3:0] mask, input logic [1:0] mode, input logic [31:0] din,
                      input logic [31:0] e_data, input logic e_ack, input logic [3:0] e_act,
                      input logic e_perr, input bit full);
    applyStimulus(tag, rst, req, mask, mode, din, e_data, e_ack, e_act, e_perr, full);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    mode_tab[0]  = 2'b01; clamp_tab[0] = 32'h0000_0000;
    mode_tab[1]  = 2'b10; clamp_tab[1] = 32'hFFFF_FFFF;
    mode_tab[2]  = 2'b11; clamp_tab[2] = 32'h5566_7788;

    rst_n = 1'b0; iso_req = 1'b0; ch_mask = '0; clamp_mode = 2'b00; data_in = '0;
    $display("[TB] start");
    @(negedge clk);

    step("reset",    1'b0, 1'b0, 4'h0, 2'b00, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 4'h0, 1'b0, 1'b1);
    step("run_idle", 1'b1, 1'b0, 4'h0, 2'b00, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 4'h0, 1'b0, 1'b1);

    // Hold-last with partial mask; mask/mode changes while isolated must be ignored
    step("hl_run",   1'b1, 1'b1, 4'b0101, 2'b00, 32'hDDCC_BBAA, 32'hDDCC_BBAA, 1'b0, 4'h0,    1'b0, 1'b1);
    step("hl_capt",  1'b1, 1'b1, 4'b0101, 2'b00, 32'hDDCC_BBAA, 32'hDDCC_BBAA, 1'b0, 4'h0,    1'b0, 1'b1);
    step("hl_iso",   1'b1, 1'b1, 4'b1111, 2'b01, 32'h1122_3344, 32'h11CC_33AA, 1'b1, 4'b0101, 1'b0, 1'b1);
    step("hl_drop",  1'b1, 1'b0, 4'b1111, 2'b01, 32'h1122_3344, 32'h11CC_33AA, 1'b1, 4'b0101, 1'b0, 1'b1);
    for (int i = 0; i < RELEASE_DLY; i++) begin
      step($sformatf("hl_rel%0d", i), 1'b1, 1'b0, 4'h0, 2'b00, 32'h1122_3344,
           32'h11CC_33AA, 1'b1, 4'b0101, 1'b0, 1'b1);
    end
    step("hl_back",  1'b1, 1'b0, 4'h0, 2'b00, 32'h1122_3344, 32'h1122_3344, 1'b0, 4'h0, 1'b0, 1'b1);

    // Clamp modes driven by a one-cycle request pulse
    for (int m = 0; m < 3; m++) begin
      step($sformatf("cm%0d_run", m),  1'b1, 1'b1, 4'hF, mode_tab[m], 32'h5566_7788,
           32'h5566_7788, 1'b0, 4'h0, 1'b0, 1'b1);
      step($sformatf("cm%0d_capt", m), 1'b1, 1'b0, 4'hF, mode_tab[m], 32'h5566_7788,
           32'h5566_7788, 1'b0, 4'h0, 1'b0, 1'b1);
      step($sformatf("cm%0d_iso", m),  1'b1, 1'b0, 4'h0, 2'b00, 32'h9999_9999,
           clamp_tab[m], 1'b1, 4'hF, 1'b0, 1'b1);
      for (int i = 0; i < RELEASE_DLY; i++) begin
        step($sformatf("cm%0d_rel%0d", m, i), 1'b1, 1'b0, 4'h0, 2'b00, 32'h9999_9999,
             clamp_tab[m], 1'b1, 4'hF, 1'b0, 1'b1);
      end
      step($sformatf("cm%0d_back", m), 1'b1, 1'b0, 4'h0, 2'b00, 32'h9999_9999,
           32'h9999_9999, 1'b0, 4'h0, 1'b0, 1'b1);
    end

    // Re-request in the second RELEASE cycle, then reset while isolated
    step("rr_run",   1'b1, 1'b1, 4'b0011, 2'b00, 32'h0A0B_0C0D, 32'h0A0B_0C0D, 1'b0, 4'h0,    1'b0, 1'b1);
    step("rr_capt",  1'b1, 1'b1, 4'b0011, 2'b00, 32'h0A0B_0C0D, 32'h0A0B_0C0D, 1'b0, 4'h0,    1'b0, 1'b1);
    step("rr_iso",   1'b1, 1'b0, 4'b0011, 2'b00, 32'hF0F0_F0F0, 32'hF0F0_0C0D, 1'b1, 4'b0011, 1'b0, 1'b1);
    step("rr_rel0",  1'b1, 1'b0, 4'b0011, 2'b00, 32'hF0F0_F0F0, 32'hF0F0_0C0D, 1'b1, 4'b0011, 1'b0, 1'b1);
    step("rr_rel1",  1'b1, 1'b1, 4'b1100, 2'b10, 32'hF0F0_F0F0, 32'hF0F0_0C0D, 1'b1, 4'b0011, 1'b0, 1'b1);
    step("rr_iso2",  1'b1, 1'b1, 4'b1100, 2'b10, 32'h1234_5678, 32'h1234_0C0D, 1'b1, 4'b0011, 1'b0, 1'b1);
    step("rst_iso",  1'b0, 1'b1, 4'b1100, 2'b10, 32'h1234_5678, 32'h1234_5678, 1'b0, 4'h0,    1'b0, 1'b1);
    step("rst_out",  1'b1, 1'b0, 4'h0,    2'b00, 32'h8765_4321, 32'h8765_4321, 1'b0, 4'h0,    1'b0, 1'b1);

`ifdef ISO_HOLD_PARITY_EN
    // Corrupt a held word while isolated; flag must stick until the next capture
    step("pe_run",   1'b1, 1'b1, 4'b0001, 2'b00, 32'h0000_005A, 32'h0000_005A, 1'b0, 4'h0, 1'b0, 1'b1);
    step("pe_capt",  1'b1, 1'b1, 4'b0001, 2'b00, 32'h0000_005A, 32'h0000_005A, 1'b0, 4'h0, 1'b0, 1'b1);
    force dut.g_chan[0].u_chan.hold_q = 8'h5B;
    step("pe_flip",  1'b1, 1'b1, 4'b0001, 2'b00, 32'h0000_005A, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    step("pe_set",   1'b1, 1'b1, 4'b0001, 2'b00, 32'h0000_005A, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    release dut.g_chan[0].u_chan.hold_q;
    step("pe_drop",  1'b1, 1'b0, 4'b0001, 2'b00, 32'h0000_005A, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < RELEASE_DLY; i++) begin
      step($sformatf("pe_rel%0d", i), 1'b1, 1'b0, 4'h0, 2'b00, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    end
    step("pe_hold",  1'b1, 1'b0, 4'h0, 2'b00, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    step("pe_run2",  1'b1, 1'b1, 4'b0001, 2'b00, 32'h0000_003C, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    step("pe_capt2", 1'b1, 1'b1, 4'b0001, 2'b00, 32'h0000_003C, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    step("pe_clr",   1'b1, 1'b0, 4'b0000, 2'b00, 32'h7777_7777, 32'h7777_773C, 1'b1, 4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < RELEASE_DLY; i++) begin
      step($sformatf("pe_rel2_%0d", i), 1'b1, 1'b0, 4'h0, 2'b00, 32'h7777_7777,
           32'h7777_773C, 1'b1, 4'b0001, 1'b0, 1'b1);
    end
    step("pe_back",  1'b1, 1'b0, 4'h0, 2'b00, 32'h7777_7777, 32'h7777_7777, 1'b0, 4'h0, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
